// File: rtl/ds_wave_source.sv
// ds_wave_source
//   Multi-channel test-signal source for the delta-sigma DAC. NUM_CH
//   independent phase generators (hold / triangle / saw-up / saw-down),
//   each stepping on its own modulator pulse-done tick. Registers are
//   written through an 8-bit two-phase byte-pair port: the low byte is
//   latched on the falling edge of data_part_in, the 16-bit word is
//   committed on the rising edge.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   data_in       register data byte
//   addr          register address {ch, r}; r=0 VALUE, r=1 CTRL
//   data_part_in  asynchronous byte-phase strobe from pins
//   tick          per-channel advance strobe (1-cycle pulses)
//   u_out         channel values, ch0 in the LSBs (registered)
//   dir_out       triangle direction per channel (1 = down)
//   wrap_pulse    1-cycle pulse: saw wrapped or triangle reflected

// One channel: control register, phase value and step logic.
module ds_wave_chan #(
    parameter int WIDTH    = 16,
    parameter int OCT_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_en,
    input  logic             wr_ctrl,
    input  logic [15:0]      wr_data,
    output logic [WIDTH-1:0] value,
    output logic             dir,
    output logic             wrap
);
    // WIDTH-1 bit 0101..01 pattern; the octave selects how far it is shifted down.
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH - 1; i += 2) p[i] = 1'b1;
        return p;
    endfunction

    localparam logic [WIDTH-1:0] ALT = alt_pattern();

    typedef enum logic [1:0] {M_HOLD, M_TRI, M_UP, M_DOWN} mode_t;

    logic [15:0]         ctrl;
    logic [OCT_BITS-1:0] octave;
    mode_t               mode;
    logic [WIDTH-1:0]    delta;
    logic [WIDTH:0]      up_sum;
    logic [WIDTH:0]      dn_diff;
    logic [WIDTH-1:0]    tri_sum;
    logic [WIDTH-1:0]    wr_word;
    logic                unused_ctrl;

    assign octave      = ctrl[OCT_BITS-1:0];
    assign mode        = mode_t'(ctrl[5:4]);
    // Upper control bits are kept for readback compatibility only.
    assign unused_ctrl = ^ctrl;

    always_comb begin
        // (2^OCT_BITS-1) - octave is simply the bitwise complement.
        delta   = ALT >> (~octave);
        up_sum  = {1'b0, value} + {1'b0, delta};
        dn_diff = {1'b0, value} - {1'b0, delta};
        tri_sum = dir ? (value - delta) : (value + delta);
        wr_word = '0;
        wr_word[WIDTH-1 -: 16] = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= {1'b1, {(WIDTH-1){1'b0}}};
            dir   <= 1'b1;
            ctrl  <= 16'h0010;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // A register write takes priority; a coincident tick is dropped.
            if (wr_en) begin
                if (wr_ctrl) ctrl  <= wr_data;
                else         value <= wr_word;
            end else if (tick) begin
                case (mode)
                    M_UP: begin
                        value <= up_sum[WIDTH-1:0];
                        wrap  <= up_sum[WIDTH];
                    end
                    M_DOWN: begin
                        value <= dn_diff[WIDTH-1:0];
                        wrap  <= dn_diff[WIDTH];
                    end
                    M_TRI: begin
                        // Reflect before entering the outer quarter; value holds on the turn.
                        if (!dir && tri_sum[WIDTH-1:WIDTH-2] == 2'b11) begin
                            dir  <= 1'b1;
                            wrap <= 1'b1;
                        end else if (dir && tri_sum[WIDTH-1:WIDTH-2] == 2'b00) begin
                            dir  <= 1'b0;
                            wrap <= 1'b1;
                        end else begin
                            value <= tri_sum;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

module ds_wave_source #(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 16,
    parameter int OCT_BITS  = 4,
    parameter int ADDR_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              data_in,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic                    data_part_in,
    input  logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*WIDTH-1:0] u_out,
    output logic [NUM_CH-1:0]       dir_out,
    output logic [NUM_CH-1:0]       wrap_pulse
);
    logic [2:0]                   sync;
    logic [7:0]                   lo_byte;
    logic                         dp;
    logic                         last;
    logic                         wr_stb;
    logic                         lo_stb;
    logic [ADDR_BITS-2:0]         ch_sel;
    logic [15:0]                  data16;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH-1:0][WIDTH-1:0] chan_val;

    // Pin enters at the MSB; the two older taps are metastability-safe.
    assign dp     = sync[1];
    assign last   = sync[0];
    assign wr_stb = dp & ~last;
    assign lo_stb = ~dp & last;
    assign ch_sel = addr[ADDR_BITS-1:1];
    assign data16 = {data_in, lo_byte};

    // Reset to all-ones so a pin held high through reset yields no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= 3'b111;
            lo_byte <= 8'h00;
        end else begin
            sync <= {data_part_in, sync[2:1]};
            if (lo_stb) lo_byte <= data_in;
        end
    end

    // Channel indices at or above NUM_CH never match, so those writes vanish.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_en[c] = wr_stb && (ch_sel == (ADDR_BITS-1)'(c));

        ds_wave_chan #(
            .WIDTH    (WIDTH),
            .OCT_BITS (OCT_BITS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick[c]),
            .wr_en   (wr_en[c]),
            .wr_ctrl (addr[0]),
            .wr_data (data16),
            .value   (chan_val[c]),
            .dir     (dir_out[c]),
            .wrap    (wrap_pulse[c])
        );
    end

    assign u_out = chan_val;
endmodule

// File: tb/tb_ds_wave_source.sv
module tb_ds_wave_source;
    localparam int NUM_CH = 2;
    localparam int WIDTH  = 16;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic [7:0]  data_in      = 8'h00;
    logic [2:0]  addr         = 3'd0;
    logic        data_part_in = 1'b1;
    logic [1:0]  tick         = 2'b00;
    logic [31:0] u_out;
    logic [1:0]  dir_out;
    logic [1:0]  wrap_pulse;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    ds_wave_source #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .OCT_BITS(4), .ADDR_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .addr         (addr),
        .data_part_in (data_part_in),
        .tick         (tick),
        .u_out        (u_out),
        .dir_out      (dir_out),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Channel state as plain integers; pin history h1..h3 = pin value
    // sampled 1, 2, 3 edges ago. A rise seen two edges back commits a write.
    int m_val [NUM_CH];
    int m_dir [NUM_CH];
    int m_ctrl[NUM_CH];
    int m_wrap[NUM_CH];
    int m_lo, h1, h2, h3;
    int m_wr, m_lat, m_d16, m_dlt, m_s;

    function automatic int delta_of(input int oct);
        int alt = 0;
        for (int i = 0; i < WIDTH - 1; i += 2) alt |= (1 << i);
        return alt >> (15 - oct);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_val[c] = 'h8000; m_dir[c] = 1; m_ctrl[c] = 'h10; m_wrap[c] = 0;
            end
            m_lo = 0; h1 = 1; h2 = 1; h3 = 1;
        end else begin
            m_wr  = (h2 == 1 && h3 == 0) ? 1 : 0;
            m_lat = (h2 == 0 && h3 == 1) ? 1 : 0;
            m_d16 = int'(data_in) * 256 + m_lo;
            if (m_lat != 0) m_lo = int'(data_in);
            for (int c = 0; c < NUM_CH; c++) begin
                m_wrap[c] = 0;
                if (m_wr != 0 && int'(addr) / 2 == c) begin
                    if (addr[0]) m_ctrl[c] = m_d16;
                    else         m_val[c]  = m_d16;
                end else if (tick[c]) begin
                    m_dlt = delta_of(m_ctrl[c] % 16);
                    case ((m_ctrl[c] / 16) % 4)
                        1: begin
                            m_s = (m_dir[c] != 0) ? m_val[c] - m_dlt : m_val[c] + m_dlt;
                            m_s = m_s & 'hFFFF;
                            if (m_dir[c] == 0 && m_s >= 'hC000) begin
                                m_dir[c] = 1; m_wrap[c] = 1;
                            end else if (m_dir[c] != 0 && m_s < 'h4000) begin
                                m_dir[c] = 0; m_wrap[c] = 1;
                            end else m_val[c] = m_s;
                        end
                        2: begin
                            m_s = m_val[c] + m_dlt;
                            m_wrap[c] = (m_s > 'hFFFF) ? 1 : 0;
                            m_val[c] = m_s & 'hFFFF;
                        end
                        3: begin
                            m_s = m_val[c] - m_dlt;
                            m_wrap[c] = (m_s < 0) ? 1 : 0;
                            m_val[c] = m_s & 'hFFFF;
                        end
                        default: ;
                    endcase
                end
            end
            h3 = h2; h2 = h1; h1 = int'(data_part_in);
        end
    end

    // Per-cycle comparison of the DUT against the model.
    logic [31:0] e_u;
    logic [1:0]  e_d, e_w;
    always @(negedge clk) begin
        if (check_en && !reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e_u[c*16 +: 16] = m_val[c][15:0];
                e_d[c] = m_dir[c][0];
                e_w[c] = m_wrap[c][0];
            end
            chk("model_u_out", u_out, e_u);
            chk("model_dir_out", {30'd0, dir_out}, {30'd0, e_d});
            chk("model_wrap", {30'd0, wrap_pulse}, {30'd0, e_w});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        addr = a; data_in = v[7:0]; data_part_in = 1'b0;
        repeat (3) @(negedge clk);
        data_in = v[15:8]; data_part_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic tk(input logic [1:0] t);
        @(negedge clk); tick = t;
        @(negedge clk); tick = 2'b00;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_u", u_out, 32'h8000_8000);
        chk("reset_dir", {30'd0, dir_out}, 32'd3);
        chk("reset_wrap", {30'd0, wrap_pulse}, 32'd0);
        #2 reset = 1'b0;
        check_en = 1'b1;

        // Saw up, octave 1 (delta 1): 0xFFFF wraps to 0.
        wr(3'd1, 16'h0021);
        wr(3'd0, 16'hFFFF);
        chk("saw_load", {16'd0, u_out[15:0]}, 32'h0000_FFFF);
        tk(2'b01);
        chk("saw_wrap_val", {16'd0, u_out[15:0]}, 32'h0);
        chk("saw_wrap_pulse", {31'd0, wrap_pulse[0]}, 32'd1);
        @(negedge clk);
        chk("saw_wrap_clear", {31'd0, wrap_pulse[0]}, 32'd0);

        // Triangle octave 15 (delta 0x5555) from 0x8000 going down: 0x2AAB is in
        // the bottom quarter, so it reflects; going up 0xD555 reflects again.
        wr(3'd1, 16'h001F);
        wr(3'd0, 16'h8000);
        tk(2'b01);
        chk("tri15_val", {16'd0, u_out[15:0]}, 32'h8000);
        chk("tri15_dir", {31'd0, dir_out[0]}, 32'd0);
        chk("tri15_wrap", {31'd0, wrap_pulse[0]}, 32'd1);
        tk(2'b01);
        chk("tri15_dir2", {31'd0, dir_out[0]}, 32'd1);

        // Triangle octave 14 (delta 0x2AAA): 0x8000 -> 0x5556 -> reflect -> 0x8000.
        wr(3'd1, 16'h001E);
        tk(2'b01);
        chk("tri14_step", {16'd0, u_out[15:0]}, 32'h5556);
        tk(2'b01);
        chk("tri14_hold", {16'd0, u_out[15:0]}, 32'h5556);
        chk("tri14_wrap", {31'd0, wrap_pulse[0]}, 32'd1);
        tk(2'b01);
        chk("tri14_up", {16'd0, u_out[15:0]}, 32'h8000);

        // Saw down octave 1 from 0: borrow.
        wr(3'd1, 16'h0031);
        wr(3'd0, 16'h0000);
        tk(2'b01);
        chk("sawdn_val", {16'd0, u_out[15:0]}, 32'hFFFF);
        chk("sawdn_wrap", {31'd0, wrap_pulse[0]}, 32'd1);

        // Hold mode ignores ticks.
        wr(3'd1, 16'h0000);
        tk(2'b01);
        chk("hold_val", {16'd0, u_out[15:0]}, 32'hFFFF);

        // Byte pair to ch1 VALUE; commit exactly two edges after the rise is sampled.
        @(negedge clk); addr = 3'd2; data_in = 8'h34; data_part_in = 1'b0;
        repeat (3) @(negedge clk);
        data_in = 8'h12; data_part_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("pair_not_yet", {16'd0, u_out[31:16]}, 32'h8000);
        @(negedge clk);
        chk("pair_k2", {16'd0, u_out[31:16]}, 32'h1234);
        chk("pair_ch0", {16'd0, u_out[15:0]}, 32'hFFFF);

        // Write/tick collision on ch1 while ch0 ticks normally.
        wr(3'd3, 16'h002F);
        wr(3'd1, 16'h0021);
        @(negedge clk); addr = 3'd2; data_in = 8'hCD; data_part_in = 1'b0;
        repeat (3) @(negedge clk);
        data_in = 8'hAB; data_part_in = 1'b1;
        repeat (2) @(negedge clk);
        tick = 2'b11;
        @(negedge clk); tick = 2'b00;
        chk("coll_ch1", {16'd0, u_out[31:16]}, 32'hABCD);
        chk("coll_ch1_wrap", {31'd0, wrap_pulse[1]}, 32'd0);
        chk("coll_ch0", {16'd0, u_out[15:0]}, 32'h0000);
        chk("coll_ch0_wrap", {31'd0, wrap_pulse[0]}, 32'd1);

        // Out-of-range channel addresses change nothing.
        for (int a = 4; a < 8; a++) wr(3'(a), 16'h5A5A);
        chk("oor_u", u_out, 32'hABCD_0000);
        tk(2'b11);
        chk("oor_step_u", u_out, 32'h0122_0001);
        chk("oor_step_wrap", {30'd0, wrap_pulse}, 32'd2);

        // Reset during the high phase with the pin held high: no write afterwards.
        @(negedge clk); addr = 3'd0; data_in = 8'h66; data_part_in = 1'b0;
        repeat (3) @(negedge clk);
        data_in = 8'h77; data_part_in = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_hi_u", u_out, 32'h8000_8000);
        chk("rst_hi_dir", {30'd0, dir_out}, 32'd3);
        chk("rst_hi_wrap", {30'd0, wrap_pulse}, 32'd0);

        // Reset with the pin held low: only a low-byte latch after release.
        @(negedge clk); data_in = 8'h99; data_part_in = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_lo_nowrite", u_out, 32'h8000_8000);
        data_in = 8'h77; data_part_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lo_pair", {16'd0, u_out[15:0]}, 32'h7799);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
